// File: rtl/als_monitor.sv
// als_monitor: periodic ambient-light poller with block averaging, hysteresis dark flag and request timeout
//   clk_i/rst_i       : clock, synchronous active-high reset
//   enable_i          : allow new requests to be issued
//   thr_lo_i/thr_hi_i : dark set / clear thresholds
//   als_ready_i       : sensor idle
//   als_fetch_o       : one-cycle request pulse
//   als_arrived_i     : one-cycle sample-valid pulse, als_illum_i carries the sample
//   level_o           : latest block average, level_valid_o pulses on update
//   dark_o            : filtered darkness flag, dark_changed_o pulses on toggle
//   timeout_o         : one-cycle pulse on an aborted request
module als_monitor #(
    parameter int PERIOD    = 1000000,
    parameter int AVG_SHIFT = 2,
    parameter int TIMEOUT   = 4096
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic [7:0] thr_lo_i,
    input  logic [7:0] thr_hi_i,
    input  logic       als_ready_i,
    output logic       als_fetch_o,
    input  logic       als_arrived_i,
    input  logic [7:0] als_illum_i,
    output logic [7:0] level_o,
    output logic       level_valid_o,
    output logic       dark_o,
    output logic       dark_changed_o,
    output logic       timeout_o
);
    localparam int PW = $clog2(PERIOD);
    localparam int TW = $clog2(TIMEOUT);
    localparam int AW = 8 + AVG_SHIFT;
    localparam int CW = (AVG_SHIFT > 0) ? AVG_SHIFT : 1;
    localparam logic [PW-1:0] P_LOAD = PW'(PERIOD - 1);
    localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] C_LAST = CW'((1 << AVG_SHIFT) - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [AW-1:0] acc_q, acc_d, sum;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    level_q, level_d;
    logic          fetch_q, fetch_d, lv_q, lv_d, dark_q, dark_d, dchg_q, dchg_d, to_q, to_d;
    logic          take, last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pcnt_q  <= P_LOAD;
            tcnt_q  <= T_LOAD;
            acc_q   <= '0;
            cnt_q   <= '0;
            level_q <= '0;
            fetch_q <= 1'b0;
            lv_q    <= 1'b0;
            dark_q  <= 1'b0;
            dchg_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            tcnt_q  <= tcnt_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            fetch_q <= fetch_d;
            lv_q    <= lv_d;
            dark_q  <= dark_d;
            dchg_q  <= dchg_d;
            to_q    <= to_d;
        end
    end

    // Leaving S_IDLE as the counter steps to zero puts the registered fetch
    // pulse exactly PERIOD cycles after S_IDLE entry.
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    pcnt_d  = pcnt_q - PW'(1);
                    state_d = (pcnt_q == PW'(1)) ? S_REQ : S_IDLE;
                end
            end
            S_REQ: begin
                if (als_ready_i) begin
                    state_d = S_WAIT;
                    tcnt_d  = T_LOAD;
                end
            end
            S_WAIT: begin
                tcnt_d = tcnt_q - TW'(1);
                if (als_arrived_i || tcnt_q == '0) begin
                    state_d = S_IDLE;
                    pcnt_d  = P_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
                pcnt_d  = P_LOAD;
            end
        endcase
    end

    always_comb begin
        take    = state_q == S_WAIT && als_arrived_i;
        last    = take && cnt_q == C_LAST;
        sum     = acc_q + AW'(als_illum_i);
        fetch_d = state_q == S_REQ && als_ready_i;
        to_d    = state_q == S_WAIT && !als_arrived_i && tcnt_q == '0;
        acc_d   = last ? '0 : take ? sum : acc_q;
        cnt_d   = last ? '0 : take ? cnt_q + CW'(1) : cnt_q;
        level_d = last ? sum[AVG_SHIFT +: 8] : level_q;
        lv_d    = last;
        // Hysteresis runs one cycle after the level update, on the registered level.
        dark_d  = !lv_q ? dark_q : dark_q ? !(level_q > thr_hi_i) : (level_q < thr_lo_i);
        dchg_d  = dark_d != dark_q;
    end

    assign als_fetch_o    = fetch_q;
    assign level_o        = level_q;
    assign level_valid_o  = lv_q;
    assign dark_o         = dark_q;
    assign dark_changed_o = dchg_q;
    assign timeout_o      = to_q;
endmodule

// File: tb/tb_als_monitor.sv
// tb_als_monitor: self-checking bench for als_monitor against an event-level reference model
module tb_als_monitor;
    localparam int PERIOD    = 10;
    localparam int AVG_SHIFT = 2;
    localparam int TIMEOUT   = 50;
    localparam int N         = 1 << AVG_SHIFT;

    logic       clk, rst, enable, als_ready, als_arrived;
    logic [7:0] thr_lo, thr_hi, als_illum;
    logic       als_fetch, level_valid, dark, dark_changed, timeout;
    logic [7:0] level;

    als_monitor #(.PERIOD(PERIOD), .AVG_SHIFT(AVG_SHIFT), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .enable_i(enable),
        .thr_lo_i(thr_lo),
        .thr_hi_i(thr_hi),
        .als_ready_i(als_ready),
        .als_fetch_o(als_fetch),
        .als_arrived_i(als_arrived),
        .als_illum_i(als_illum),
        .level_o(level),
        .level_valid_o(level_valid),
        .dark_o(dark),
        .dark_changed_o(dark_changed),
        .timeout_o(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 requesting, 2 waiting; timing kept as
    // counts of enabled idle cycles and absolute edge numbers.
    int         cyc = 0;
    int         phase = 0, idle_n = 0, t_fetch = 0, started = 0, do_eval = 0;
    int         samples[$];
    logic       m_fetch = 0, m_lv = 0, m_dark = 0, m_dchg = 0, m_to = 0;
    logic [7:0] m_level = 0;

    always @(posedge clk) begin
        int s;
        cyc = cyc + 1;
        started = 1;
        m_fetch = 0; m_lv = 0; m_dchg = 0; m_to = 0;
        if (rst) begin
            phase = 0; idle_n = 0; do_eval = 0;
            samples.delete();
            m_level = 0; m_dark = 0;
        end else begin
            if (do_eval != 0) begin
                if (!m_dark && m_level < thr_lo) begin m_dark = 1; m_dchg = 1; end
                else if (m_dark && m_level > thr_hi) begin m_dark = 0; m_dchg = 1; end
            end
            do_eval = 0;
            if (phase == 0) begin
                if (enable) begin
                    idle_n = idle_n + 1;
                    if (idle_n == PERIOD - 1) phase = 1;
                end
            end else if (phase == 1) begin
                if (als_ready) begin m_fetch = 1; t_fetch = cyc; phase = 2; end
            end else if (als_arrived) begin
                samples.push_back(int'(als_illum));
                phase = 0; idle_n = 0;
                if (samples.size() == N) begin
                    s = 0;
                    foreach (samples[i]) s = s + samples[i];
                    m_level = 8'(s / N);
                    m_lv = 1; do_eval = 1;
                    samples.delete();
                end
            end else if (cyc - t_fetch == TIMEOUT) begin
                m_to = 1; phase = 0; idle_n = 0;
            end
        end
    end

    // Literal expectations posted by the stimulus; only the stimulus writes these.
    string lit_name[$];
    int    lit_act[$], lit_exp[$];
    int    lit_rd = 0, n_chk = 0, n_fail = 0;

    always @(negedge clk) begin
        logic [12:0] act, exp;
        if (started != 0) begin
            act = {als_fetch, level_valid, level, dark, dark_changed, timeout};
            exp = {m_fetch, m_lv, m_level, m_dark, m_dchg, m_to};
            n_chk = n_chk + 1;
            if (act !== exp) begin
                n_fail = n_fail + 1;
                $display("FAIL model cyc%0d {fetch,lv,level,dark,dchg,to}: got %h expected %h", cyc, act, exp);
            end
        end
        while (lit_rd < lit_act.size()) begin
            n_chk = n_chk + 1;
            if (lit_act[lit_rd] != lit_exp[lit_rd]) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got %0d expected %0d", lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
            end
            lit_rd = lit_rd + 1;
        end
    end

    task automatic post(input string nm, input int act, input int exp);
        lit_name.push_back(nm);
        lit_act.push_back(act);
        lit_exp.push_back(exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fetch(output int fc);
        int k = 0;
        while (!als_fetch && k < 300) begin tick(); k++; end
        if (!als_fetch) post("fetch_wait_expired", 0, 1);
        fc = cyc;
    endtask

    task automatic respond(input int dly, input int v);
        repeat (dly) tick();
        als_arrived = 1; als_illum = 8'(v);
        tick();
        als_arrived = 0;
    endtask

    task automatic txn(input int dly, input int v, output int fc);
        wait_fetch(fc);
        respond(dly, v);
    endtask

    task automatic block(input int v, input int exp_dark, input int exp_dchg);
        int fc;
        repeat (3) txn(3, v, fc);
        txn(3, v + 3, fc);
        post("block_level", int'(level), v);
        post("block_lv", int'(level_valid), 1);
        tick();
        post("block_dark", int'(dark), exp_dark);
        post("block_dchg", int'(dark_changed), exp_dchg);
    endtask

    initial begin
        int f[4];
        int fa, fb, t0, k;
        logic seen;
        rst = 1; enable = 0; thr_lo = 0; thr_hi = 80; als_ready = 1; als_arrived = 0; als_illum = 0;
        repeat (3) tick();
        post("rst_level", int'(level), 0);
        post("rst_dark", int'(dark), 0);
        post("rst_fetch", int'(als_fetch), 0);
        rst = 0; enable = 1; t0 = cyc;
        // cadence and averaging with truncation: 101/4 = 25
        txn(20, 10, f[0]);
        txn(20, 20, f[1]);
        txn(20, 30, f[2]);
        txn(20, 41, f[3]);
        post("first_fetch", f[0] - t0, PERIOD);
        for (int i = 1; i < 4; i++) post("cadence", f[i] - f[i-1], 31);
        post("lv_after4", int'(level_valid), 1);
        post("level_trunc", int'(level), 25);
        tick();
        post("dark_thr0", int'(dark), 0);
        // hysteresis with thr_lo=50, thr_hi=80
        thr_lo = 50;
        block(100, 0, 0);
        block(40, 1, 1);
        block(60, 1, 0);
        block(90, 0, 1);
        block(85, 0, 0);
        // timeout in the middle of a block keeps the partial sum
        txn(3, 8, fa);
        txn(3, 8, fa);
        wait_fetch(fa);
        k = 0;
        while (!timeout && k < 100) begin tick(); k++; end
        post("timeout_delay", cyc - fa, TIMEOUT);
        t0 = cyc;
        txn(3, 8, fb);
        post("fetch_after_timeout", fb - t0, PERIOD);
        txn(3, 9, fb);
        post("level_across_timeout", int'(level), 8);
        tick();
        // sensor not ready: no fetch, no timeout until ready rises
        als_ready = 0; seen = 0;
        repeat (110) begin tick(); seen = seen | als_fetch | timeout; end
        post("no_fetch_not_ready", int'(seen), 0);
        als_ready = 1; t0 = cyc;
        txn(3, 60, fa);
        post("fetch_on_ready", fa - t0, 1);
        // stray arrival while idle
        als_arrived = 1; als_illum = 200;
        tick();
        als_arrived = 0;
        post("stray_level", int'(level), 8);
        post("stray_lv", int'(level_valid), 0);
        txn(3, 60, fa);
        txn(3, 60, fa);
        txn(3, 63, fa);
        post("level_after_stray", int'(level), 60);
        tick();
        // reset during wait, then a late arrival right after release
        wait_fetch(fa);
        repeat (5) tick();
        rst = 1;
        tick();
        post("rst_wait_level", int'(level), 0);
        post("rst_wait_dark", int'(dark), 0);
        rst = 0; t0 = cyc;
        als_arrived = 1; als_illum = 77;
        tick();
        als_arrived = 0;
        post("late_arrival_lv", int'(level_valid), 0);
        txn(3, 4, fa);
        post("fetch_after_rst", fa - t0, PERIOD);
        repeat (3) txn(3, 4, fa);
        post("level_after_rst", int'(level), 4);
        tick();
        // enable dropped mid-transaction: sample kept, then parked
        wait_fetch(fa);
        enable = 0;
        respond(3, 200);
        seen = 0;
        repeat (40) begin tick(); seen = seen | als_fetch; end
        post("no_fetch_disabled", int'(seen), 0);
        enable = 1;
        txn(3, 200, fa);
        txn(3, 200, fa);
        txn(3, 203, fa);
        post("level_kept_disabled", int'(level), 200);
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
